// File: rtl/mc_alu_if.sv
// rtl/mc_alu_if.sv - Start/Busy/Done operand and result bundle for mc_alu
interface mc_alu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] ResultHi;
    logic             Zero;
    logic             DivByZero;

    modport master (
        output Start, ALUControl, OpA, OpB,
        input  Busy, Done, ALUResult, ResultHi, Zero, DivByZero
    );

    modport slave (
        input  Start, ALUControl, OpA, OpB,
        output Busy, Done, ALUResult, ResultHi, Zero, DivByZero
    );
endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: 1-cycle ops, shift-add MULU, restoring DIVU when MC_ALU_DIV_EN is defined
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    mc_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MULU = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
`ifdef MC_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1100;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef MC_ALU_DIV_EN
        , DIV
`endif
    } state_t;

    state_t           state, state_n;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc, mq, opb_q;
    logic [WIDTH-1:0] acc_n, mq_n;
    logic [WIDTH-1:0] res1;
    logic [WIDTH:0]   mul_sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_result_q, result_hi_q;
    logic             zero_q, dbz_q, done_q;
`ifdef MC_ALU_DIV_EN
    logic [WIDTH:0]   rem_sh, div_diff;
    logic             dbz_pend;
`endif

    assign shamt = bus.OpB[SHW-1:0];

    always_comb begin
        res1 = '0;
        case (bus.ALUControl)
            OP_AND:  res1 = bus.OpA & bus.OpB;
            OP_OR:   res1 = bus.OpA | bus.OpB;
            OP_ADD:  res1 = bus.OpA + bus.OpB;
            OP_XOR:  res1 = bus.OpA ^ bus.OpB;
            OP_SUB:  res1 = bus.OpA - bus.OpB;
            OP_SLT:  res1 = {{(WIDTH-1){1'b0}}, ($signed(bus.OpA) < $signed(bus.OpB))};
            OP_SLTU: res1 = {{(WIDTH-1){1'b0}}, (bus.OpA < bus.OpB)};
            OP_SLL:  res1 = bus.OpA << shamt;
            OP_SRL:  res1 = bus.OpA >> shamt;
            OP_SRA:  res1 = $signed(bus.OpA) >>> shamt;
            OP_NOR:  res1 = ~(bus.OpA | bus.OpB);
            default: res1 = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.ALUControl == OP_MULU) state_n = MUL;
`ifdef MC_ALU_DIV_EN
                    else if (bus.ALUControl == OP_DIVU) state_n = DIV;
`endif
                end
            end
            default: if (cnt == '0) state_n = IDLE;
        endcase
    end

    // {acc,mq} is the shared shift pair: product hi/lo for MUL, remainder/quotient for DIV
    always_comb begin
        mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb_q} : '0);
        acc_n   = mul_sum[WIDTH:1];
        mq_n    = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef MC_ALU_DIV_EN
        rem_sh   = {acc, mq[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opb_q};
        if (state == DIV) begin
            acc_n = div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            mq_n  = {mq[WIDTH-2:0], ~div_diff[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            acc          <= '0;
            mq           <= '0;
            opb_q        <= '0;
            alu_result_q <= '0;
            result_hi_q  <= '0;
            zero_q       <= 1'b1;
            dbz_q        <= 1'b0;
            done_q       <= 1'b0;
`ifdef MC_ALU_DIV_EN
            dbz_pend     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.Start) begin
                    cnt   <= SHW'(WIDTH-1);
                    acc   <= '0;
                    mq    <= bus.OpA;
                    opb_q <= bus.OpB;
`ifdef MC_ALU_DIV_EN
                    dbz_pend <= (bus.OpB == '0);
`endif
                    if (state_n == IDLE) begin
                        alu_result_q <= res1;
                        result_hi_q  <= '0;
                        zero_q       <= (res1 == '0);
                        dbz_q        <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
            end else begin
                acc <= acc_n;
                mq  <= mq_n;
                cnt <= cnt - SHW'(1);
                if (cnt == '0) begin
                    alu_result_q <= mq_n;
                    result_hi_q  <= acc_n;
                    zero_q       <= (mq_n == '0);
                    done_q       <= 1'b1;
`ifdef MC_ALU_DIV_EN
                    dbz_q        <= (state == DIV) && dbz_pend;
`else
                    dbz_q        <= 1'b0;
`endif
                end
            end
        end
    end

    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = done_q;
    assign bus.ALUResult = alu_result_q;
    assign bus.ResultHi  = result_hi_q;
    assign bus.Zero      = zero_q;
    assign bus.DivByZero = dbz_q;
endmodule
